// File: rtl/shift_register_universal_if.sv
// Bus bundle for the universal shift register: operation controls, burst handshake
// and register outputs. The master drives the controls and the slave is the register.
interface shift_register_universal_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic             sin_l;
  logic             sin_r;
  logic [CNT_W-1:0] count;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, load_data, sin_l, sin_r, count, start,
    input  out, sout_l, sout_r, busy, done
  );

  modport slave (
    input  en, mode, load_data, sin_l, sin_r, count, start,
    output out, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/shift_register_universal.sv
// N-bit universal shift register with direct single-step operations and a counted
// burst engine (start/busy/done) that repeats a latched shift or rotate mode.
module shift_register_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  shift_register_universal_if.slave bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             sout_l_q, sout_r_q, sl_nxt, sr_nxt;
  logic             done_q, done_nxt;
  logic             do_op, latch;
  logic [2:0]       op_mode;

  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) || (m == M_ROR) || (m == M_ASR);
  endfunction

  function automatic logic [WIDTH-1:0] asr1(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return $unsigned(s >>> 1);
  endfunction

  // State register plus burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
      mode_q <= M_HOLD;
      rem_q  <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (latch) begin
        mode_q <= bus.mode;
        rem_q  <= bus.count;
      end else if (state == BUSY && do_op) begin
        rem_q  <= rem_q - CNT_W'(1);
      end
    end
  end

  // Next-state: decides whether an operation happens this edge and which mode it uses
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    do_op     = 1'b0;
    latch     = 1'b0;
    op_mode   = bus.mode;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0 && is_burst_mode(bus.mode)) begin
            state_nxt = BUSY;
            latch     = 1'b1;
          end else begin
            done_nxt  = 1'b1;
          end
        end else if (bus.en) begin
          do_op = 1'b1;
        end
      end
      BUSY: begin
        op_mode = mode_q;
        if (bus.en) begin
          do_op = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next value; serial-out bits only move on the ops that shift past them
  always_comb begin
    data_nxt = data_q;
    sl_nxt   = sout_l_q;
    sr_nxt   = sout_r_q;
    if (do_op) begin
      case (op_mode)
        M_SHL: begin data_nxt = {data_q[WIDTH-2:0], bus.sin_r};     sl_nxt = data_q[WIDTH-1]; end
        M_SHR: begin data_nxt = {bus.sin_l, data_q[WIDTH-1:1]};     sr_nxt = data_q[0];       end
        M_ROL: begin data_nxt = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; sl_nxt = data_q[WIDTH-1]; end
        M_ROR: begin data_nxt = {data_q[0], data_q[WIDTH-1:1]};     sr_nxt = data_q[0];       end
        M_ASR: begin data_nxt = asr1(data_q);                       sr_nxt = data_q[0];       end
        M_LOAD: data_nxt = bus.load_data;
        default: data_nxt = data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      sout_l_q <= 1'b0;
      sout_r_q <= 1'b0;
    end else begin
      data_q   <= data_nxt;
      sout_l_q <= sl_nxt;
      sout_r_q <= sr_nxt;
    end
  end

  assign bus.out    = data_q;
  assign bus.sout_l = sout_l_q;
  assign bus.sout_r = sout_r_q;
  assign bus.busy   = (state == BUSY);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=8, CNT_W=4): per-scenario stimulus tables
// with expected snapshots queued on drive and popped after each clock edge.
module tb_shift_register_universal;

  localparam logic [2:0] HOLD = 3'b000, SHL = 3'b001, SHR = 3'b010, ROL = 3'b011;
  localparam logic [2:0] ROR  = 3'b100, ASR = 3'b101, LOAD = 3'b110, RSV = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  shift_register_universal_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_register_universal #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, en;
    logic [2:0] mode;
    logic [7:0] ld;
    logic       sl, sr;
    logic [3:0] cnt;
    logic       start;
    logic [7:0] eo;
    logic       esl, esr, ebusy, edone;
  } row_t;

  typedef logic [11:0] snap_t;
  snap_t sb[$];

  function automatic row_t r(input logic rs, input logic en, input logic [2:0] m,
                             input logic [7:0] ld, input logic sl, input logic sr,
                             input logic [3:0] cnt, input logic st, input logic [7:0] eo,
                             input logic esl, input logic esr, input logic eb, input logic ed);
    row_t x;
    x.rst = rs; x.en = en; x.mode = m; x.ld = ld; x.sl = sl; x.sr = sr;
    x.cnt = cnt; x.start = st; x.eo = eo; x.esl = esl; x.esr = esr;
    x.ebusy = eb; x.edone = ed;
    return x;
  endfunction

  task automatic drive(input row_t x);
    rst           = x.rst;
    bus.en        = x.en;
    bus.mode      = x.mode;
    bus.load_data = x.ld;
    bus.sin_l     = x.sl;
    bus.sin_r     = x.sr;
    bus.count     = x.cnt;
    bus.start     = x.start;
    sb.push_back({x.eo, x.esl, x.esr, x.ebusy, x.edone});
  endtask

  task automatic test_reset();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(1,0,HOLD,8'h00,0,0,4'd0,0, 8'h00,0,0,0,0));
    rows.push_back(r(1,0,HOLD,8'h00,0,0,4'd0,0, 8'h00,0,0,0,0));
    rows.push_back(r(0,1,LOAD,8'hFF,0,0,4'd0,0, 8'hFF,0,0,0,0));
    rows.push_back(r(0,1,SHL ,8'h00,0,0,4'd0,0, 8'hFE,1,0,0,0));
    rows.push_back(r(1,1,ROL ,8'h00,0,0,4'd3,1, 8'h00,0,0,0,0));
    rows.push_back(r(1,1,ROL ,8'h00,0,0,4'd3,1, 8'h00,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_direct();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(0,1,LOAD,8'hA5,0,0,4'd0,0, 8'hA5,0,0,0,0));
    rows.push_back(r(0,1,SHL ,8'h00,0,1,4'd0,0, 8'h4B,1,0,0,0));
    rows.push_back(r(0,1,LOAD,8'hA5,0,0,4'd0,0, 8'hA5,1,0,0,0));
    rows.push_back(r(0,1,SHR ,8'h00,0,0,4'd0,0, 8'h52,1,1,0,0));
    rows.push_back(r(0,1,LOAD,8'h80,0,0,4'd0,0, 8'h80,1,1,0,0));
    rows.push_back(r(0,1,ASR ,8'h00,0,0,4'd0,0, 8'hC0,1,0,0,0));
    rows.push_back(r(0,0,SHL ,8'h00,0,1,4'd0,0, 8'hC0,1,0,0,0));
    rows.push_back(r(0,0,LOAD,8'h33,0,0,4'd0,0, 8'hC0,1,0,0,0));
    rows.push_back(r(0,1,ROR ,8'h00,0,0,4'd0,0, 8'h60,1,0,0,0));
    rows.push_back(r(0,1,ROL ,8'h00,0,0,4'd0,0, 8'hC0,0,0,0,0));
    rows.push_back(r(0,1,RSV ,8'h11,1,1,4'd0,0, 8'hC0,0,0,0,0));
    rows.push_back(r(0,1,HOLD,8'h22,1,1,4'd0,0, 8'hC0,0,0,0,0));
    rows.push_back(r(0,1,SHR ,8'h00,1,0,4'd0,0, 8'hE0,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL direct step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_burst_rol();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(0,1,LOAD,8'h81,0,0,4'd0,0, 8'h81,0,0,0,0));
    rows.push_back(r(0,1,ROL ,8'h00,0,0,4'd3,1, 8'h81,0,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h03,1,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h06,0,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h0C,0,0,0,1));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h0C,0,0,0,0));
    // same burst with one stalled cycle in the middle
    rows.push_back(r(0,1,LOAD,8'h81,0,0,4'd0,0, 8'h81,0,0,0,0));
    rows.push_back(r(0,1,ROL ,8'h00,0,0,4'd3,1, 8'h81,0,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h03,1,0,1,0));
    rows.push_back(r(0,0,HOLD,8'h00,0,0,4'd0,0, 8'h03,1,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h06,0,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h0C,0,0,0,1));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h0C,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst_rol step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_degenerate();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(0,1,ROL ,8'h00,0,0,4'd0,1, 8'h0C,0,0,0,1));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h0C,0,0,0,0));
    rows.push_back(r(0,1,LOAD,8'hEE,0,0,4'd5,1, 8'h0C,0,0,0,1));
    rows.push_back(r(0,1,HOLD,8'hEE,0,0,4'd0,0, 8'h0C,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL degenerate step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(0,1,LOAD,8'hFF,0,0,4'd0,0, 8'hFF,0,0,0,0));
    rows.push_back(r(0,1,SHR ,8'h00,0,0,4'd4,1, 8'hFF,0,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h7F,0,1,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h3F,0,1,1,0));
    rows.push_back(r(1,1,HOLD,8'h00,0,0,4'd0,0, 8'h00,0,0,0,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h00,0,0,0,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,0,4'd0,0, 8'h00,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_ignored_while_busy();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(0,1,LOAD,8'h01,0,0,4'd0,0, 8'h01,0,0,0,0));
    rows.push_back(r(0,1,ROR ,8'h00,0,0,4'd2,1, 8'h01,0,0,1,0));
    rows.push_back(r(0,1,LOAD,8'h55,0,0,4'd7,1, 8'h80,0,1,1,0));
    rows.push_back(r(0,1,LOAD,8'h55,0,0,4'd7,1, 8'h40,0,0,0,1));
    rows.push_back(r(0,1,HOLD,8'h55,0,0,4'd0,0, 8'h40,0,0,0,0));
    rows.push_back(r(0,1,HOLD,8'h55,0,0,4'd0,0, 8'h40,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ignored step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    snap_t e, o;
    rows.push_back(r(0,1,ROL ,8'h00,0,0,4'd1,1, 8'h40,0,0,1,0));
    rows.push_back(r(0,1,SHL ,8'h00,0,1,4'd2,1, 8'h80,0,0,0,1));
    rows.push_back(r(0,1,SHL ,8'h00,0,1,4'd2,1, 8'h80,0,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,1,4'd0,0, 8'h01,1,0,1,0));
    rows.push_back(r(0,1,HOLD,8'h00,0,1,4'd0,0, 8'h03,0,0,0,1));
    rows.push_back(r(0,1,HOLD,8'h00,0,1,4'd0,0, 8'h03,0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {bus.out, bus.sout_l, bus.sout_r, bus.busy, bus.done};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got out=%h sl=%b sr=%b busy=%b done=%b, want out=%h sl=%b sr=%b busy=%b done=%b",
                 i, o[11:4], o[3], o[2], o[1], o[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.mode      = HOLD;
    bus.load_data = '0;
    bus.sin_l     = 1'b0;
    bus.sin_r     = 1'b0;
    bus.count     = '0;
    bus.start     = 1'b0;
    test_reset();
    test_direct();
    test_burst_rol();
    test_degenerate();
    test_reset_mid_burst();
    test_ignored_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
